md_tx_responder: RTL and testbench

Synthesizable MD-protocol responder that terminates the aligner's MD TX port, the slave end of the md_tx_* handshake. It checks each transfer for legality, inserts a programmable number of wait cycles before asserting ready, and flags illegal transfers with err. Payload bytes from legal transfers are packed into a byte FIFO and re-emitted as full bus-width words on a valid/ready stream. It replaces the bench-driven tx_drv_cb model in system-level simulation and on FPGA.

---
 rtl/md_tx_responder.sv | 138 +++++++++++++
 tb/tb_md_tx_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_tx_responder.sv
// MD TX responder: terminates the aligner's md_tx_* port, checks each transfer for legality,
// inserts programmable wait cycles and repacks accepted payload bytes into full bus words.
module md_tx_responder #(
    parameter int unsigned ALGN_DATA_WIDTH = 32,
    parameter int unsigned BUS_BYTES       = ALGN_DATA_WIDTH / 8,
    parameter int unsigned OFFSET_W        = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1,
    parameter int unsigned SIZE_W          = $clog2(BUS_BYTES) + 1,
    parameter int unsigned FIFO_BYTES      = 2 * BUS_BYTES
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        md_tx_valid,
    input  logic [ALGN_DATA_WIDTH-1:0]  md_tx_data,
    input  logic [OFFSET_W-1:0]         md_tx_offset,
    input  logic [SIZE_W-1:0]           md_tx_size,
    output logic                        md_tx_ready,
    output logic                        md_tx_err,
    input  logic [3:0]                  cfg_wait,
    output logic                        out_valid,
    output logic [ALGN_DATA_WIDTH-1:0]  out_data,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_BYTES):0] fifo_level,
    output logic [15:0]                 cnt_ok,
    output logic [15:0]                 cnt_err
);
    localparam int unsigned LEVEL_W = $clog2(FIFO_BYTES) + 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_BYTES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                     state_q;
    logic [3:0]                 wait_q;
    logic [ALGN_DATA_WIDTH-1:0] resp_bytes_q;
    logic [SIZE_W-1:0]          resp_size_q;
    logic [7:0]                 mem_q [FIFO_BYTES];
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;

    logic [SIZE_W:0]            end_sum;
    logic                       legal;
    logic [LEVEL_W-1:0]         free_bytes;
    logic                       has_space;
    logic                       push;
    logic                       pop;
    logic [LEVEL_W-1:0]         push_cnt;
    logic [LEVEL_W-1:0]         pop_cnt;

    always_comb begin
        // One extra bit so offset + size cannot wrap back into the legal range.
        end_sum    = (SIZE_W+1)'(md_tx_offset) + (SIZE_W+1)'(md_tx_size);
        legal      = (md_tx_size != '0) && (end_sum <= (SIZE_W+1)'(BUS_BYTES));
        free_bytes = LEVEL_W'(FIFO_BYTES) - fifo_level;
        has_space  = free_bytes >= LEVEL_W'(md_tx_size);
        push       = (state_q == StResp) && !md_tx_err;
        out_valid  = fifo_level >= LEVEL_W'(BUS_BYTES);
        pop        = out_valid && out_ready;
        push_cnt   = push ? LEVEL_W'(resp_size_q) : '0;
        pop_cnt    = pop ? LEVEL_W'(BUS_BYTES) : '0;
        out_data   = '0;
        for (int i = 0; i < int'(BUS_BYTES); i++) begin
            out_data[8*i +: 8] = mem_q[rd_ptr_q + PTR_W'(i)];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            md_tx_ready  <= 1'b0;
            md_tx_err    <= 1'b0;
            resp_bytes_q <= '0;
            resp_size_q  <= '0;
            cnt_ok       <= '0;
            cnt_err      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    md_tx_ready <= 1'b0;
                    md_tx_err   <= 1'b0;
                    if (md_tx_valid) begin
                        wait_q  <= cfg_wait;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!md_tx_valid) begin
                        state_q <= StIdle;
                    end else if (wait_q != '0) begin
                        wait_q <= wait_q - 4'd1;
                    end else if (!legal || has_space) begin
                        state_q      <= StResp;
                        md_tx_ready  <= 1'b1;
                        md_tx_err    <= !legal;
                        // Pre-align so the first payload byte sits in bits [7:0].
                        resp_bytes_q <= md_tx_data >> {md_tx_offset, 3'b000};
                        resp_size_q  <= md_tx_size;
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    md_tx_ready <= 1'b0;
                    md_tx_err   <= 1'b0;
                    if (md_tx_err) begin
                        if (cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
                    end else begin
                        if (cnt_ok != 16'hFFFF) cnt_ok <= cnt_ok + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_BYTES); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                for (int i = 0; i < int'(BUS_BYTES); i++) begin
                    if (i < int'(resp_size_q)) begin
                        mem_q[wr_ptr_q + PTR_W'(i)] <= resp_bytes_q[8*i +: 8];
                    end
                end
                wr_ptr_q <= wr_ptr_q + PTR_W'(resp_size_q);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(BUS_BYTES);
            end
            fifo_level <= fifo_level + push_cnt - pop_cnt;
        end
    end

endmodule

// File: tb/tb_md_tx_responder.sv
// Self-checking bench for md_tx_responder: directed scenarios plus randomized transfers
// checked against a byte-queue reference model.
module tb_md_tx_responder;
    localparam int BUS = 4;

    logic        clk;
    logic        reset_n;
    logic        md_tx_valid;
    logic [31:0] md_tx_data;
    logic [1:0]  md_tx_offset;
    logic [2:0]  md_tx_size;
    logic        md_tx_ready;
    logic        md_tx_err;
    logic [3:0]  cfg_wait;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    md_tx_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .md_tx_valid  (md_tx_valid),
        .md_tx_data   (md_tx_data),
        .md_tx_offset (md_tx_offset),
        .md_tx_size   (md_tx_size),
        .md_tx_ready  (md_tx_ready),
        .md_tx_err    (md_tx_err),
        .cfg_wait     (cfg_wait),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .cnt_ok       (cnt_ok),
        .cnt_err      (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: bytes buffered in arrival order, bytes to be pushed on the next edge,
    // and saturating transfer counters.
    logic [7:0] mq[$];
    logic [7:0] pend[$];
    int         m_ok  = 0;
    int         m_err = 0;

    logic [31:0] cur_d;
    int          cur_off;
    int          cur_sz;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_word();
        return {mq[3], mq[2], mq[1], mq[0]};
    endfunction

    // One clock edge: apply model pop/push, then compare the FIFO view 1 time unit later.
    task automatic tick();
        bit do_pop;
        do_pop = (mq.size() >= BUS) && (out_ready === 1'b1);
        @(posedge clk);
        if (do_pop) repeat (BUS) void'(mq.pop_front());
        while (pend.size() > 0) mq.push_back(pend.pop_front());
        #1;
        check("fifo_level", 64'(fifo_level), 64'(mq.size()));
        check("out_valid", 64'(out_valid), 64'(mq.size() >= BUS));
        if (mq.size() >= BUS) check("out_data", 64'(out_data), 64'(model_word()));
    endtask

    task automatic xfer_start(input logic [31:0] d, input int off, input int sz);
        cur_d        = d;
        cur_off      = off;
        cur_sz       = sz;
        md_tx_valid  = 1'b1;
        md_tx_data   = d;
        md_tx_offset = 2'(off);
        md_tx_size   = 3'(sz);
    endtask

    // Wait (bounded) for ready, check latency/err, then complete the RESP cycle.
    task automatic xfer_wait(input int exp_lat);
        int k;
        bit legal;
        legal = (cur_sz != 0) && (cur_off + cur_sz <= BUS);
        k = 0;
        do begin
            tick();
            k++;
        end while (md_tx_ready !== 1'b1 && k < 64);
        check("ready_seen", 64'(md_tx_ready), 64'(1));
        if (exp_lat >= 0) check("latency", 64'(k), 64'(exp_lat));
        check("err", 64'(md_tx_err), 64'(!legal));
        if (legal) begin
            for (int i = 0; i < cur_sz; i++) pend.push_back(cur_d[8*(cur_off+i) +: 8]);
            if (m_ok < 16'hFFFF) m_ok++;
        end else begin
            if (m_err < 16'hFFFF) m_err++;
        end
        tick();
        md_tx_valid = 1'b0;
        check("ready_drop", 64'(md_tx_ready), 64'(0));
        check("cnt_ok", 64'(cnt_ok), 64'(m_ok));
        check("cnt_err", 64'(cnt_err), 64'(m_err));
    endtask

    task automatic run_xfer(input logic [31:0] d, input int off, input int sz, input int lat);
        xfer_start(d, off, sz);
        xfer_wait(lat);
    endtask

    initial begin
        int k;
        int w;
        int off;
        int sz;
        reset_n      = 1'b0;
        md_tx_valid  = 1'b0;
        md_tx_data   = '0;
        md_tx_offset = '0;
        md_tx_size   = '0;
        cfg_wait     = '0;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(md_tx_ready), 64'(0));
        check("rst_err", 64'(md_tx_err), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_cnt_ok", 64'(cnt_ok), 64'(0));
        check("rst_cnt_err", 64'(cnt_err), 64'(0));
        reset_n = 1'b1;
        tick();

        // Legal pair packs into one word.
        run_xfer(32'hDDCCBBAA, 0, 2, 2);
        run_xfer(32'h44332211, 1, 2, 2);
        check("pack_valid", 64'(out_valid), 64'(1));
        check("pack_word", 64'(out_data), 64'h3322BBAA);
        tick();
        check("pack_drained", 64'(fifo_level), 64'(0));
        check("pack_cnt_ok", 64'(cnt_ok), 64'(2));

        // Illegal transfers.
        run_xfer(32'h12345678, 3, 2, 2);
        run_xfer(32'h12345678, 0, 0, 2);
        check("ill_cnt_err", 64'(cnt_err), 64'(2));
        check("ill_level", 64'(fifo_level), 64'(0));

        // Wait insertion; leaves 3 bytes buffered.
        cfg_wait = 4'd5;
        run_xfer(32'hA1B2C3D4, 1, 3, 7);
        check("wait_level", 64'(fifo_level), 64'(3));

        // Asynchronous reset in the middle of WAIT.
        xfer_start(32'h0BADF00D, 0, 4);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ready", 64'(md_tx_ready), 64'(0));
        check("arst_err", 64'(md_tx_err), 64'(0));
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_out_data", 64'(out_data), 64'(0));
        check("arst_level", 64'(fifo_level), 64'(0));
        check("arst_cnt_ok", 64'(cnt_ok), 64'(0));
        check("arst_cnt_err", 64'(cnt_err), 64'(0));
        mq.delete();
        pend.delete();
        m_ok  = 0;
        m_err = 0;
        md_tx_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arst_no_ready", 64'(md_tx_ready), 64'(0));
        end

        // Backpressure: third word waits until the downstream pops.
        cfg_wait  = 4'd0;
        out_ready = 1'b0;
        run_xfer($urandom, 0, 4, 2);
        run_xfer($urandom, 0, 4, 2);
        check("bp_full", 64'(fifo_level), 64'(8));
        xfer_start($urandom, 0, 4);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("bp_hold", 64'(md_tx_ready), 64'(0));
        end
        out_ready = 1'b1;
        xfer_wait(2);
        repeat (3) tick();

        // Master drops valid during WAIT: no response, no count.
        cfg_wait = 4'd4;
        xfer_start(32'hCAFEBABE, 0, 4);
        repeat (3) tick();
        md_tx_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("drop_no_ready", 64'(md_tx_ready), 64'(0));
        end
        check("drop_cnt_ok", 64'(cnt_ok), 64'(m_ok));

        // Randomized transfers, mostly legal.
        for (int t = 0; t < 40; t++) begin
            w        = int'($urandom_range(0, 3));
            cfg_wait = 4'(w);
            off      = int'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) sz = int'($urandom_range(0, 7));
            else sz = int'($urandom_range(1, 4 - off));
            run_xfer($urandom, off, sz, 2 + w);
        end

        // Saturation: preload counters near the top, then keep counting.
        cfg_wait = 4'd0;
        force dut.cnt_ok = 16'hFFFE;
        force dut.cnt_err = 16'hFFFE;
        tick();
        release dut.cnt_ok;
        release dut.cnt_err;
        m_ok  = 16'hFFFE;
        m_err = 16'hFFFE;
        run_xfer($urandom, 0, 1, 2);
        run_xfer($urandom, 1, 2, 2);
        run_xfer($urandom, 2, 3, 2);
        run_xfer($urandom, 0, 0, 2);
        check("sat_cnt_ok", 64'(cnt_ok), 64'hFFFF);
        check("sat_cnt_err", 64'(cnt_err), 64'hFFFF);
        k = 0;
        while (mq.size() >= BUS && k < 8) begin
            tick();
            k++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
